// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl: 5-stage MIPS stall/flush sequencing with MDU busy tracking.
// Optional perf counters under HAZARD_PERF_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_valid,
  input  logic             id_is_mdu,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MDU_RUN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdu_busy_q, mdu_busy_d;
  logic             lu_haz, mdu_haz, stall;

  always_comb begin
    lu_haz  = id_valid & ex_mem_read & (ex_rt != '0) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    mdu_haz = (state_q == MDU_RUN) & id_valid & (id_is_mdu | id_reads_hilo);
    stall   = lu_haz | mdu_haz;
  end

  // Stall outranks flush: branch operands are not valid while stalled.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mdu_busy_d = mdu_busy_q;
    case (state_q)
      RUN: begin
        if (id_valid & id_is_mdu & !stall) begin
          state_d    = MDU_RUN;
          cnt_d      = CNT_LOAD;
          mdu_busy_d = 1'b1;
        end
      end
      MDU_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d    = RUN;
          mdu_busy_d = 1'b0;
        end
      end
      default: begin
        state_d    = RUN;
        cnt_d      = '0;
        mdu_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mdu_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mdu_busy_q <= mdu_busy_d;
    end
  end

  assign mdu_busy = mdu_busy_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall};
    flush_count_d  = flush_count_q + {31'd0, ifid_flush};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl: directed self-checking bench, MDU_LATENCY=4.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 0, id_valid = 0, id_is_mdu = 0, id_reads_hilo = 0;
  logic        ex_mem_read = 0, branch_taken = 0;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy;
  logic [31:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.REG_W(5), .MDU_LATENCY(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_valid(id_valid),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .mdu_busy(mdu_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy}
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy}, {27'd0, exp});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; id_valid = 0; id_is_mdu = 0; id_reads_hilo = 0;
    ex_mem_read = 0; branch_taken = 0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk_out("reset_outputs", 5'b11000);
    chk("reset_stall_cnt", stall_cycles, 32'd0);
    chk("reset_flush_cnt", flush_count, 32'd0);
    nxt();
    reset = 1'b0;

    // Load-use on rs
    id_valid = 1; ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk); chk_out("lu_rs_stall", 5'b00010);
    nxt(); ex_mem_read = 0;
    @(negedge clk); chk_out("lu_rs_release", 5'b11000);
    nxt(); ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk); chk_out("lu_r0_nostall", 5'b11000);

    // rt-only dependency
    nxt(); ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 0;
    @(negedge clk); chk_out("lu_rt_unused", 5'b11000);
    nxt(); id_uses_rt = 1;
    @(negedge clk); chk_out("lu_rt_used", 5'b00010);

    // Branch flush, then branch under load-use
    nxt(); clr(); branch_taken = 1;
    @(negedge clk); chk_out("branch_flush", 5'b11100);
    nxt(); branch_taken = 0;
    @(negedge clk); chk_out("branch_done", 5'b11000);
    nxt(); id_valid = 1; ex_mem_read = 1; ex_rt = 5'd4; id_rs = 5'd4; branch_taken = 1;
    @(negedge clk); chk_out("branch_vs_stall", 5'b00010);

    // mult then mfhi: 4 stalled cycles
    nxt(); clr(); id_valid = 1; id_is_mdu = 1;
    @(negedge clk); chk_out("mult_issue", 5'b11000);
    nxt(); id_is_mdu = 0; id_reads_hilo = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk_out($sformatf("mfhi_stall_%0d", i), 5'b00011);
      nxt();
    end
    @(negedge clk); chk_out("mfhi_accept", 5'b11000);

    // MDU issue blocked by simultaneous load-use
    nxt(); clr(); id_valid = 1; id_is_mdu = 1; ex_mem_read = 1; ex_rt = 5'd7; id_rs = 5'd7;
    @(negedge clk); chk_out("mdu_vs_lu", 5'b00010);
    nxt(); ex_mem_read = 0;
    @(negedge clk); chk_out("mdu_after_lu", 5'b11000);
    nxt(); clr();
    @(negedge clk); chk_out("mdu_run_c1", 5'b11001);
    nxt();
    @(negedge clk); chk_out("mdu_run_c2", 5'b11001);
    chk("stall_cnt_pre_reset", stall_cycles, PERF ? 32'd8 : 32'd0);
    chk("flush_cnt_pre_reset", flush_count, PERF ? 32'd1 : 32'd0);

    // Async reset mid-MDU
    reset = 1'b1;
    #1;
    chk_out("reset_mid_mdu", 5'b11000);
    chk("reset_clears_stall_cnt", stall_cycles, 32'd0);
    nxt(); reset = 1'b0;

    // Full latency window after reset
    id_valid = 1; id_is_mdu = 1;
    @(negedge clk); chk_out("mult2_issue", 5'b11000);
    nxt(); id_is_mdu = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk_out($sformatf("mult2_busy_%0d", i), 5'b11001);
      nxt();
    end
    @(negedge clk); chk_out("mult2_done", 5'b11000);

    // MDU op in ID during the cnt==0 cycle of MDU_RUN
    nxt(); id_is_mdu = 1;
    @(negedge clk); chk_out("mult3_issue", 5'b11000);
    for (int i = 0; i < 4; i++) begin
      nxt();
      @(negedge clk); chk_out($sformatf("mult4_stall_%0d", i), 5'b00011);
    end
    nxt();
    @(negedge clk); chk_out("mult4_accept", 5'b11000);
    nxt(); clr(); branch_taken = 1;
    @(negedge clk); chk_out("flush_after_reset", 5'b11101);
    nxt(); branch_taken = 0;
    @(negedge clk);
    chk("stall_cnt_final", stall_cycles, PERF ? 32'd4 : 32'd0);
    chk("flush_cnt_final", flush_count, PERF ? 32'd1 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
